// File: rtl/seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_param
// Brief    : Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with
//            per-transaction signed/unsigned mode and valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_m_mag;
    logic [WIDTH-1:0]     r_q_mag;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH-1:0]     w_m_mag;
    logic [WIDTH-1:0]     w_q_mag;
    logic [WIDTH-1:0]     w_q_shift;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_last;

    // Negating -2^(WIDTH-1) wraps to itself, which reads correctly as an unsigned magnitude
    assign w_m_mag    = (is_signed && m[WIDTH-1]) ? -m : m;
    assign w_q_mag    = (is_signed && q[WIDTH-1]) ? -q : q;
    assign w_q_shift  = r_q_mag >> r_cnt;
    assign w_addend   = {{WIDTH{1'b0}}, r_m_mag} << r_cnt;
    assign w_acc_next = w_q_shift[0] ? (r_acc + w_addend) : r_acc;
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);
    assign p         = r_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_m_mag <= '0;
            r_q_mag <= '0;
            r_neg   <= 1'b0;
            r_p     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_m_mag <= w_m_mag;
                        r_q_mag <= w_q_mag;
                        r_neg   <= is_signed & (m[WIDTH-1] ^ q[WIDTH-1]);
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // Sign is applied once on the final sum, modulo 2^(2*WIDTH)
                        r_p     <= r_neg ? -w_acc_next : w_acc_next;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_acc   <= '0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_param
// Brief    : Directed self-checking bench for seq_mult_param at WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_param;

    localparam int WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   q;
    logic               is_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    int checks;
    int failures;

    seq_mult_param #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .q         (q),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accepts one operand pair; returns after out_valid is seen (or the bound expires)
    task automatic start_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic s, input logic rdy, input logic [15:0] exp);
        int cyc;
        @(negedge clk);
        m         = a;
        q         = b;
        is_signed = s;
        in_valid  = 1'b1;
        out_ready = rdy;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        m         = 8'($urandom);
        q         = 8'($urandom);
        is_signed = 1'($urandom);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'd8);
        check_eq({tag, "_p"}, 32'(p), 32'(exp));
        check_eq({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [15:0] exp);
        start_op(tag, a, b, s, 1'b1, exp);
        @(posedge clk);
        #1;
        check_eq({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_handoff_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_p_held"}, 32'(p), 32'(exp));
    endtask

    initial begin
        logic [7:0]         ra;
        logic [7:0]         rb;
        logic               rs;
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic [15:0]        rexp;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        m         = '0;
        q         = '0;
        is_signed = 1'b0;
        out_ready = 1'b0;

        #2;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_p", 32'(p), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F);
        run_op("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run_op("s_m1xm1", 8'hFF, 8'hFF, 1'b1, 16'h0001);
        run_op("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
        run_op("s_m128x127", 8'h80, 8'h7F, 1'b1, 16'hC080);
        run_op("s_m7x5", 8'hF9, 8'h05, 1'b1, 16'hFFDD);
        run_op("s_zero", 8'h00, 8'h85, 1'b1, 16'h0000);
        run_op("u_zero", 8'hAB, 8'h00, 1'b0, 16'h0000);

        // Backpressure: product must sit unchanged while the sink stalls
        start_op("bp", 8'd6, 8'd7, 1'b0, 1'b0, 16'd42);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
            check_eq("bp_p", 32'(p), 32'd42);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release_valid", 32'(out_valid), 32'd0);
        check_eq("bp_release_ready", 32'(in_ready), 32'd1);

        // Asynchronous abort in the middle of CALC
        @(negedge clk);
        m         = 8'd100;
        q         = 8'd3;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_p", 32'(p), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        check_eq("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_abort", 8'd2, 8'd3, 1'b0, 16'd6);

        // Mixed vectors with idle gaps, expected value from a plain multiply
        for (int k = 0; k < 24; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            sa = rs ? 16'($signed(ra)) : 16'(ra);
            sb = rs ? 16'($signed(rb)) : 16'(rb);
            rexp = 16'(sa * sb);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op("sweep", ra, rb, rs, rexp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
